// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter shared by instruction fetch and data ports
module mem_port_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic        err,
  output logic        stall_if,
  output logic        stall_mem
);
  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;  // 1 = data port owns the transaction
  logic          we_q, we_d;
  logic [SW-1:0] dstreak_q, dstreak_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          err_q, err_d;
  logic          grant_if;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    dstreak_d   = dstreak_q;
    tcnt_d      = tcnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    grant_if    = 1'b0;
    case (state_q)
      IDLE: begin
        grant_if = if_req && (!d_req || dstreak_q == SW'(MAX_DSTREAK));
        if (if_req || d_req) begin
          state_d  = ISSUE;
          owner_d  = !grant_if;
          mem_en_d = 1'b1;
          tcnt_d   = '0;
          if (grant_if) begin
            we_d        = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            dstreak_d   = '0;
          end else begin
            we_d        = d_we;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            // Only data grants that make a fetch wait count toward starvation.
            if (if_req && dstreak_q != SW'(MAX_DSTREAK)) begin
              dstreak_d = dstreak_q + SW'(1);
            end
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        tcnt_d  = '0;
      end
      WAIT: begin
        if (mem_valid || tcnt_q == TW'(TIMEOUT)) begin
          state_d  = RESP;
          if_ack_d = !owner_q;
          d_ack_d  = owner_q;
          err_d    = !mem_valid;
          if (owner_q) begin
            d_rdata_d = (mem_valid && !we_q) ? mem_rdata : '0;
          end else begin
            if_rdata_d = mem_valid ? mem_rdata : '0;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      dstreak_q   <= '0;
      tcnt_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      dstreak_q   <= dstreak_d;
      tcnt_q      <= tcnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_mem = d_req & ~d_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int MAXD = 4;
  localparam int TMO  = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, d_req, d_we, mem_valid;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, mem_en, mem_we, err, stall_if, stall_mem;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_DSTREAK(MAXD), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .err(err), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    int          lat;        // 0 = memory never answers
    int          exp_cyc;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic        auto_mem, prev_en;
  logic [31:0] prev_addr;
  vec_t        vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  // One clock; an enabled auto-responder answers every strobe one cycle later.
  task automatic step();
    @(posedge clk);
    #1;
    mem_valid = auto_mem && prev_en;
    mem_rdata = mem_f(prev_addr);
    prev_en   = mem_en;
    prev_addr = mem_addr;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    if_req    = 1'b0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    if_addr   = '0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    prev_en   = 1'b0;
    prev_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_if_ack"}, 32'(if_ack), 32'd0);
    chk({tag, "_d_ack"}, 32'(d_ack), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int ack_k;
    int en_cnt;
    ack_k  = -1;
    en_cnt = 0;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int k = 1; k <= 30 && ack_k < 0; k++) begin
      @(posedge clk);
      #1;
      mem_valid = (v.lat > 0) && (k == 1 + v.lat);
      mem_rdata = mem_valid ? v.mdata : 32'hBAD0_BAD0;
      if (mem_en) en_cnt++;
      if (k == 1) begin
        chk("vec_mem_en", 32'(mem_en), 32'd1);
        chk("vec_mem_addr", mem_addr, v.addr);
        chk("vec_mem_we", 32'(mem_we), 32'(v.is_d && v.we));
        chk("vec_mem_wdata", mem_wdata, v.is_d ? v.wdata : 32'd0);
        chk("vec_stall_pending", 32'(v.is_d ? stall_mem : stall_if), 32'd1);
      end
      if (if_ack || d_ack) begin
        ack_k = k;
        chk("vec_ack_owner", 32'(d_ack), 32'(v.is_d));
        chk("vec_rdata", v.is_d ? d_rdata : if_rdata, v.exp_rdata);
        chk("vec_err", 32'(err), 32'(v.exp_err));
        chk("vec_stall_at_ack", 32'(v.is_d ? stall_mem : stall_if), 32'd0);
      end
    end
    chk("vec_ack_cycle", 32'(ack_k), 32'(v.exp_cyc));
    if_req = 1'b0; d_req = 1'b0; mem_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("vec_single_strobe", 32'(en_cnt), 32'd1);
    chk("vec_ack_pulse", 32'(if_ack | d_ack | err), 32'd0);
  endtask

  initial begin
    int          d_k, i_k, dcnt, ifcnt;
    int          issue_c, ack_c, valid_c, free_c, streak;
    logic        g_d, g_we, g_to, gi, e_ia, e_da;
    logic [31:0] g_addr, g_wdata;

    auto_mem = 1'b0;
    reset_n  = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    mem_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    do_reset();

    vt[0] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0, 32'h2002_000A, 1, 3, 32'h2002_000A, 1'b0};
    vt[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h1234_5678, 1, 3, 32'h0, 1'b0};
    vt[2] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 3, 5, 32'hCAFE_F00D, 1'b0};
    vt[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 16, 18, 32'hFFFF_FFFF, 1'b0};
    vt[4] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h0, 0, 18, 32'h0, 1'b1};
    vt[5] = '{1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'h0, 0, 18, 32'h0, 1'b1};
    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Simultaneous requests: data first, fetch after the intervening idle cycle.
    auto_mem = 1'b1; prev_en = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h300;
    d_k = -1; i_k = -1;
    for (int k = 1; k <= 20 && i_k < 0; k++) begin
      step();
      if (d_ack) begin d_k = k; chk("both_d_rdata", d_rdata, mem_f(32'h100)); d_req = 1'b0; end
      if (if_ack) begin i_k = k; chk("both_if_rdata", if_rdata, mem_f(32'h300)); if_req = 1'b0; end
    end
    chk("both_d_ack_cycle", 32'(d_k), 32'd3);
    chk("both_if_ack_cycle", 32'(i_k), 32'd7);

    // Starvation guard: four data grants, then fetch, then the streak restarts.
    do_reset();
    auto_mem = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    if_req = 1'b1; if_addr = 32'h600;
    dcnt = 0; ifcnt = 0;
    for (int k = 1; k <= 80 && ifcnt < 2; k++) begin
      step();
      if (d_ack) dcnt++;
      if (if_ack) begin
        ifcnt++;
        chk(ifcnt == 1 ? "streak_first" : "streak_second", 32'(dcnt), 32'(MAXD));
        dcnt = 0;
      end
    end
    chk("streak_if_grants", 32'(ifcnt), 32'd2);
    if_req = 1'b0; d_req = 1'b0;
    repeat (6) step();

    // Reset while waiting on memory, then a stray completion after release.
    do_reset();
    auto_mem = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
    step();
    chk("rst_issue_mem_en", 32'(mem_en), 32'd1);
    step();
    reset_n = 1'b0;
    #1;
    check_quiet("rst_wait");
    step();
    reset_n = 1'b1; d_req = 1'b0;
    step();
    mem_valid = 1'b1; mem_rdata = 32'h1357_9BDF;
    for (int k = 0; k < 5; k++) begin
      step();
      check_quiet("rst_after");
    end
    auto_mem = 1'b1; prev_en = 1'b0;
    if_req = 1'b1; if_addr = 32'h880;
    i_k = -1;
    for (int k = 1; k <= 10 && i_k < 0; k++) begin
      step();
      if (if_ack) begin i_k = k; if_req = 1'b0; end
    end
    chk("rst_recover_if_ack", 32'(i_k), 32'd3);
    auto_mem = 1'b0;
    repeat (2) step();

    // Randomized traffic against a transaction-level latency model.
    do_reset();
    issue_c = -1; ack_c = -1; valid_c = -1; free_c = 0; streak = 0;
    g_d = 1'b0; g_we = 1'b0; g_to = 1'b0; g_addr = '0; g_wdata = '0;
    for (int c = 0; c < 3000; c++) begin
      e_ia = (c == ack_c) && !g_d;
      e_da = (c == ack_c) && g_d;
      chk("rnd_mem_en", 32'(mem_en), 32'(c == issue_c));
      if (c == issue_c) begin
        chk("rnd_mem_addr", mem_addr, g_addr);
        chk("rnd_mem_we", 32'(mem_we), 32'(g_d && g_we));
        if (!g_d || g_we) chk("rnd_mem_wdata", mem_wdata, g_wdata);
      end
      chk("rnd_if_ack", 32'(if_ack), 32'(e_ia));
      chk("rnd_d_ack", 32'(d_ack), 32'(e_da));
      chk("rnd_err", 32'(err), 32'((c == ack_c) && g_to));
      if (c == ack_c)
        chk("rnd_rdata", g_d ? d_rdata : if_rdata, (g_to || g_we) ? 32'd0 : mem_f(g_addr));
      if (e_ia) if_req = 1'b0;
      if (e_da) d_req = 1'b0;
      if (!if_req && ($urandom % 3 == 0)) begin if_req = 1'b1; if_addr = $urandom; end
      if (!d_req && ($urandom % 3 == 0)) begin
        d_req = 1'b1; d_we = 1'($urandom % 2); d_addr = $urandom; d_wdata = $urandom;
      end
      if (c == valid_c) begin
        mem_valid = 1'b1; mem_rdata = mem_f(g_addr);
      end else begin
        mem_valid = !(c > issue_c && c < ack_c) && ($urandom % 8 == 0);
        mem_rdata = $urandom;
      end
      if (c >= free_c && (if_req || d_req)) begin
        gi = if_req && (!d_req || streak == MAXD);
        if (gi) streak = 0;
        else if (if_req && streak < MAXD) streak++;
        g_d     = !gi;
        g_we    = !gi && d_we;
        g_addr  = gi ? if_addr : d_addr;
        g_wdata = gi ? 32'd0 : d_wdata;
        g_to    = ($urandom % 12 == 0);
        issue_c = c + 1;
        if (g_to) begin
          valid_c = -1;
          ack_c   = c + 3 + TMO;
        end else begin
          valid_c = c + 2 + int'($urandom % 4);
          ack_c   = valid_c + 1;
        end
        free_c = ack_c + 1;
      end
      #1;
      chk("rnd_stall_if", 32'(stall_if), 32'(if_req && !e_ia));
      chk("rnd_stall_mem", 32'(stall_mem), 32'(d_req && !e_da));
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
